fake_rd_gen: RTL and testbench

Parametrised, multi-channel generator of fake Radio Detector (RD) data. It emulates the RD side of the RD serial link for bench and in-system testing of the RD receive interface. After a synchronised, delayed trigger it drives a gated transfer clock and NCH parallel serial lanes. Each lane carries NWORDS frames, and each frame is WORD_W data bits (MSB first) followed by an odd-parity bit. Pattern and error-injection modes are selectable.

---
 rtl/fake_rd_pkg.sv | 32 +++
 rtl/fake_rd_gen_if.sv | 31 +++
 rtl/fake_rd_lane.sv | 63 ++++++
 rtl/rd_synchronizer.sv | 23 ++
 rtl/fake_rd_gen.sv | 201 ++++++++++++++++++++
 tb/tb_fake_rd_gen.sv | 370 +++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/fake_rd_pkg.sv
// Shared definitions for the fake RD data generator.
//   - FSM state codes (plain localparams so older tools can reuse them)
//   - pattern mode encodings
//   - counter width helpers
package fake_rd_pkg;

  typedef enum logic [1:0] {
    MODE_RAMP  = 2'd0,
    MODE_WALK  = 2'd1,
    MODE_CONST = 2'd2,
    MODE_PERR  = 2'd3
  } mode_e;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_DELAY = 3'd1;
  localparam state_t ST_PRE   = 3'd2;
  localparam state_t ST_DATA  = 3'd3;
  localparam state_t ST_POST  = 3'd4;

  // Word counter must hold 0..NWORDS-1; sized with headroom to NWORDS.
  function automatic int wcnt_w(input int nwords);
    return $clog2(nwords + 1);
  endfunction

  // Bit counter runs 0..WORD_W (last value is the parity slot).
  function automatic int bcnt_w(input int word_w);
    return $clog2(word_w + 1);
  endfunction

endpackage

// File: rtl/fake_rd_gen_if.sv
// Control and serial-link bundle of the fake RD generator.
//   ENABLE, TRIGGER : asynchronous requests into the generator
//   MODE            : pattern select, latched at trigger acceptance
//   XFR_CLK         : gated transfer clock
//   SERIAL_OUT      : NCH serial lanes
//   BUSY, DONE      : transfer status
//   DBG1, DBG2      : registered debug copies of gate and lane 0
// master = generator side, slave = receiver / controller side.
interface fake_rd_gen_if #(
  parameter int NCH = 2
);
  logic           ENABLE;
  logic           TRIGGER;
  logic [1:0]     MODE;
  logic           XFR_CLK;
  logic [NCH-1:0] SERIAL_OUT;
  logic           BUSY;
  logic           DONE;
  logic           DBG1;
  logic           DBG2;

  modport master (
    input  ENABLE, TRIGGER, MODE,
    output XFR_CLK, SERIAL_OUT, BUSY, DONE, DBG1, DBG2
  );

  modport slave (
    output ENABLE, TRIGGER, MODE,
    input  XFR_CLK, SERIAL_OUT, BUSY, DONE, DBG1, DBG2
  );
endinterface

// File: rtl/fake_rd_lane.sv
// One serial lane: pattern generation, parity and the frame shift register.
//   LOCAL_CLK, RST_N : clock, synchronous active-low reset
//   load             : next cycle is bit 0 of frame 'word'
//   shift            : next cycle is a later bit of the current frame
//   mode             : latched pattern mode
//   word             : index of the frame being loaded
//   sout             : registered lane output, idles high
module fake_rd_lane
  import fake_rd_pkg::*;
#(
  parameter int          LANE      = 0,
  parameter int          WORD_W    = 12,
  parameter int          WCW       = 12,
  parameter int          ERR_WORD  = 3,
  parameter logic [15:0] CONST_PAT = 16'h0A5A
) (
  input  logic           LOCAL_CLK,
  input  logic           RST_N,
  input  logic           load,
  input  logic           shift,
  input  mode_e          mode,
  input  logic [WCW-1:0] word,
  output logic           sout
);
  logic [WORD_W-1:0] ramp_up, ramp_dn, walk, data;
  logic [WORD_W-1:0] sh;
  logic              par;
  int                walk_idx;

  always_comb begin
    ramp_up  = WORD_W'(word);
    ramp_dn  = '0 - ramp_up;
    walk_idx = int'(word) % WORD_W;
    walk     = '0;
    for (int i = 0; i < WORD_W; i++) begin
      if (i == walk_idx) walk[i] = 1'b1;
    end
    case (mode)
      MODE_WALK:  data = walk;
      MODE_CONST: data = CONST_PAT[WORD_W-1:0];
      default:    data = (LANE % 2 == 0) ? ramp_up : ramp_dn;
    endcase
    // Odd parity over data+parity; the error mode flips it on one word.
    par = ~^data;
    if (mode == MODE_PERR && int'(word) == ERR_WORD) par = ~par;
  end

  // sh holds the bits still to be sent, next bit at the MSB.
  always_ff @(posedge LOCAL_CLK) begin
    if (!RST_N) begin
      sout <= 1'b1;
      sh   <= '0;
    end else if (load) begin
      sout <= data[WORD_W-1];
      sh   <= {data[WORD_W-2:0], par};
    end else if (shift) begin
      sout <= sh[WORD_W-1];
      sh   <= {sh[WORD_W-2:0], 1'b0};
    end else begin
      sout <= 1'b1;
    end
  end
endmodule

// File: rtl/rd_synchronizer.sv
// Two-flop synchroniser for a single asynchronous level.
//   LOCAL_CLK : destination clock
//   RST_N     : synchronous active-low reset (output resets low)
//   d         : asynchronous input
//   q         : synchronised output
module rd_synchronizer (
  input  logic LOCAL_CLK,
  input  logic RST_N,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge LOCAL_CLK) begin
    if (!RST_N) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/fake_rd_gen.sv
// Fake Radio Detector data generator: after a synchronised, delayed trigger
// it runs a gated transfer clock and NCH serial lanes carrying NWORDS frames
// of WORD_W data bits (MSB first) plus an odd-parity bit.
//   LOCAL_CLK : sole clock
//   RST_N     : synchronous active-low reset
//   rd        : control / serial-link bundle (master side)
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | waiting for a trigger edge, gate off, lanes high
// DELAY    | TRIG_DLY cycles after trigger acceptance
// PRE      | gate on, lanes high, PRE_CLKS cycles
// DATA     | NWORDS frames of WORD_W+1 bits
// POST     | gate on, lanes high, POST_CLKS cycles, then DONE
module fake_rd_gen
  import fake_rd_pkg::*;
#(
  parameter int          NCH       = 2,
  parameter int          WORD_W    = 12,
  parameter int          NWORDS    = 2048,
  parameter int          TRIG_DLY  = 20,
  parameter int          PRE_CLKS  = 4,
  parameter int          POST_CLKS = 12,
  parameter logic [15:0] CONST_PAT = 16'h0A5A,
  parameter int          ERR_WORD  = 3
) (
  input  logic          LOCAL_CLK,
  input  logic          RST_N,
  fake_rd_gen_if.master rd
);
  localparam int WCW = wcnt_w(NWORDS);
  localparam int BCW = bcnt_w(WORD_W);
  localparam logic [7:0]     DLY_LD    = 8'(TRIG_DLY - 1);
  localparam logic [7:0]     PRE_LD    = 8'(PRE_CLKS - 1);
  localparam logic [7:0]     POST_LD   = 8'(POST_CLKS - 1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(NWORDS - 1);
  localparam logic [BCW-1:0] PAR_BIT   = BCW'(WORD_W);

  logic           en_s, trig_s, trig_d, trig_edge;
  state_t         state, state_n;
  logic [7:0]     tmr, tmr_n;
  logic [WCW-1:0] word_cnt, word_n;
  logic [BCW-1:0] bit_cnt, bit_n;
  mode_e          mode_q, mode_n;
  logic           busy, busy_n, done_q, done_n;
  logic           gate, gate_n, dbg1, dbg2;
  logic           lane_load, lane_shift;
  logic [NCH-1:0] lane_bits;

  rd_synchronizer u_sync_en (
    .LOCAL_CLK (LOCAL_CLK),
    .RST_N     (RST_N),
    .d         (rd.ENABLE),
    .q         (en_s)
  );

  rd_synchronizer u_sync_trig (
    .LOCAL_CLK (LOCAL_CLK),
    .RST_N     (RST_N),
    .d         (rd.TRIGGER),
    .q         (trig_s)
  );

  assign trig_edge = trig_s & ~trig_d;

  always_comb begin
    state_n = state;
    tmr_n   = tmr;
    word_n  = word_cnt;
    bit_n   = bit_cnt;
    mode_n  = mode_q;
    busy_n  = busy;
    done_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (trig_edge) begin
          state_n = ST_DELAY;
          tmr_n   = DLY_LD;
          word_n  = '0;
          bit_n   = '0;
          mode_n  = mode_e'(rd.MODE);
          busy_n  = 1'b1;
        end
      end
      ST_DELAY: begin
        if (tmr == '0) begin
          if (PRE_CLKS == 0) begin
            state_n = ST_DATA;
          end else begin
            state_n = ST_PRE;
            tmr_n   = PRE_LD;
          end
        end else begin
          tmr_n = tmr - 8'd1;
        end
      end
      ST_PRE: begin
        if (tmr == '0) state_n = ST_DATA;
        else           tmr_n   = tmr - 8'd1;
      end
      ST_DATA: begin
        if (bit_cnt == PAR_BIT) begin
          bit_n = '0;
          if (word_cnt == LAST_WORD) begin
            if (POST_CLKS == 0) begin
              state_n = ST_IDLE;
              busy_n  = 1'b0;
              done_n  = 1'b1;
            end else begin
              state_n = ST_POST;
              tmr_n   = POST_LD;
            end
          end else begin
            word_n = word_cnt + 1'b1;
          end
        end else begin
          bit_n = bit_cnt + 1'b1;
        end
      end
      ST_POST: begin
        if (tmr == '0) begin
          state_n = ST_IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          tmr_n = tmr - 8'd1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
      end
    endcase
    // Disable aborts silently; trigger edges seen meanwhile are lost.
    if (!en_s) begin
      state_n = ST_IDLE;
      busy_n  = 1'b0;
      done_n  = 1'b0;
    end
  end

  // Outputs are registered from next-state so lanes and gate line up with
  // the state they belong to.
  assign gate_n     = (state_n == ST_PRE) || (state_n == ST_DATA) || (state_n == ST_POST);
  assign lane_load  = (state_n == ST_DATA) && (bit_n == '0);
  assign lane_shift = (state_n == ST_DATA) && (bit_n != '0);

  always_ff @(posedge LOCAL_CLK) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      tmr      <= '0;
      word_cnt <= '0;
      bit_cnt  <= '0;
      mode_q   <= MODE_RAMP;
      busy     <= 1'b0;
      done_q   <= 1'b0;
      gate     <= 1'b0;
      trig_d   <= 1'b0;
      dbg1     <= 1'b0;
      dbg2     <= 1'b1;
    end else begin
      state    <= state_n;
      tmr      <= tmr_n;
      word_cnt <= word_n;
      bit_cnt  <= bit_n;
      mode_q   <= mode_n;
      busy     <= busy_n;
      done_q   <= done_n;
      gate     <= gate_n;
      trig_d   <= trig_s;
      dbg1     <= gate;
      dbg2     <= lane_bits[0];
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    fake_rd_lane #(
      .LANE      (c),
      .WORD_W    (WORD_W),
      .WCW       (WCW),
      .ERR_WORD  (ERR_WORD),
      .CONST_PAT (CONST_PAT)
    ) u_lane (
      .LOCAL_CLK (LOCAL_CLK),
      .RST_N     (RST_N),
      .load      (lane_load),
      .shift     (lane_shift),
      .mode      (mode_q),
      .word      (word_n),
      .sout      (lane_bits[c])
    );
  end

  // Gate registered on the rising edge, so XFR_CLK rises mid-bit.
  assign rd.XFR_CLK    = gate ? ~LOCAL_CLK : 1'b1;
  assign rd.SERIAL_OUT = lane_bits;
  assign rd.BUSY       = busy;
  assign rd.DONE       = done_q;
  assign rd.DBG1       = dbg1;
  assign rd.DBG2       = dbg2;
endmodule

// File: tb/tb_fake_rd_gen.sv
// Directed bench for fake_rd_gen: two instances (12-bit/4-word with pre-clocks,
// 4-bit/6-word with no pre-clocks) decoded by per-instance frame monitors.
module tb_fake_rd_gen;
  import fake_rd_pkg::*;

  localparam int A_W = 12, A_NW = 4, A_DLY = 5, A_PRE = 4, A_POST = 12, A_ERR = 2;
  localparam int B_W = 4,  B_NW = 6, B_DLY = 1, B_PRE = 0, B_POST = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fake_rd_gen_if #(.NCH(2)) a_if ();
  fake_rd_gen_if #(.NCH(2)) b_if ();

  fake_rd_gen #(
    .NCH(2), .WORD_W(A_W), .NWORDS(A_NW), .TRIG_DLY(A_DLY), .PRE_CLKS(A_PRE),
    .POST_CLKS(A_POST), .CONST_PAT(16'h0A5A), .ERR_WORD(A_ERR)
  ) dut_a (
    .LOCAL_CLK (clk),
    .RST_N     (rst_n),
    .rd        (a_if.master)
  );

  fake_rd_gen #(
    .NCH(2), .WORD_W(B_W), .NWORDS(B_NW), .TRIG_DLY(B_DLY), .PRE_CLKS(B_PRE),
    .POST_CLKS(B_POST), .CONST_PAT(16'h0A5A), .ERR_WORD(3)
  ) dut_b (
    .LOCAL_CLK (clk),
    .RST_N     (rst_n),
    .rd        (b_if.master)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Hand-computed mode-0 words and their odd-parity bits.
  logic [11:0] a_exp     [2][4] = '{'{12'h000, 12'h001, 12'h002, 12'h003},
                                    '{12'h000, 12'hFFF, 12'hFFE, 12'hFFD}};
  logic        a_exp_par [2][4] = '{'{1'b1, 1'b0, 1'b0, 1'b1},
                                    '{1'b1, 1'b1, 1'b0, 1'b0}};
  logic [3:0]  b_walk    [6]    = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2};

  // Monitor state for instance A
  int          a_gate, a_done, a_bad_done, a_first_gate, a_first_busy, a_trig;
  int          ma_idx, ma_wd, ma_bt;
  logic [15:0] a_word [2][A_NW];
  logic        a_par  [2][A_NW];
  // Monitor state for instance B
  int          b_gate, b_done, b_bad_done, b_first_gate, b_first_busy, b_trig;
  int          mb_idx, mb_wd, mb_bt;
  logic [15:0] b_word [2][B_NW];
  logic        b_par  [2][B_NW];

  always @(posedge clk) cyc++;

  // XFR_CLK is low during the clock-high phase exactly when the gate is on.
  always @(posedge clk) begin
    #1;
    if (a_if.XFR_CLK === 1'b0) begin
      if (a_first_gate < 0) a_first_gate = cyc;
      if (a_gate >= A_PRE && a_gate < A_PRE + A_NW * (A_W + 1)) begin
        ma_idx = a_gate - A_PRE;
        ma_wd  = ma_idx / (A_W + 1);
        ma_bt  = ma_idx % (A_W + 1);
        for (int c = 0; c < 2; c++) begin
          if (ma_bt < A_W) a_word[c][ma_wd][A_W-1-ma_bt] = a_if.SERIAL_OUT[c];
          else             a_par[c][ma_wd] = a_if.SERIAL_OUT[c];
        end
      end
      a_gate++;
    end
    if (a_if.BUSY === 1'b1 && a_first_busy < 0) a_first_busy = cyc;
    if (a_if.DONE === 1'b1) begin
      a_done++;
      if (a_if.BUSY !== 1'b0) a_bad_done++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (b_if.XFR_CLK === 1'b0) begin
      if (b_first_gate < 0) b_first_gate = cyc;
      if (b_gate >= B_PRE && b_gate < B_PRE + B_NW * (B_W + 1)) begin
        mb_idx = b_gate - B_PRE;
        mb_wd  = mb_idx / (B_W + 1);
        mb_bt  = mb_idx % (B_W + 1);
        for (int c = 0; c < 2; c++) begin
          if (mb_bt < B_W) b_word[c][mb_wd][B_W-1-mb_bt] = b_if.SERIAL_OUT[c];
          else             b_par[c][mb_wd] = b_if.SERIAL_OUT[c];
        end
      end
      b_gate++;
    end
    if (b_if.BUSY === 1'b1 && b_first_busy < 0) b_first_busy = cyc;
    if (b_if.DONE === 1'b1) begin
      b_done++;
      if (b_if.BUSY !== 1'b0) b_bad_done++;
    end
  end

  task automatic start_a(input logic [1:0] mode);
    @(posedge clk); #1;
    a_gate = 0; a_done = 0; a_bad_done = 0; a_first_gate = -1; a_first_busy = -1;
    for (int c = 0; c < 2; c++)
      for (int w = 0; w < A_NW; w++) begin
        a_word[c][w] = '0;
        a_par[c][w]  = 1'b0;
      end
    a_if.MODE = mode;
    a_if.TRIGGER = 1'b1;
    a_trig = cyc;
    repeat (4) @(posedge clk);
    #1 a_if.TRIGGER = 1'b0;
  endtask

  task automatic start_b(input logic [1:0] mode);
    @(posedge clk); #1;
    b_gate = 0; b_done = 0; b_bad_done = 0; b_first_gate = -1; b_first_busy = -1;
    for (int c = 0; c < 2; c++)
      for (int w = 0; w < B_NW; w++) begin
        b_word[c][w] = '0;
        b_par[c][w]  = 1'b0;
      end
    b_if.MODE = mode;
    b_if.TRIGGER = 1'b1;
    b_trig = cyc;
    repeat (4) @(posedge clk);
    #1 b_if.TRIGGER = 1'b0;
  endtask

  task automatic wait_idle_a();
    bit seen = 1'b0;
    bit ok = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      if (a_if.BUSY === 1'b1) seen = 1'b1;
      else if (seen) begin ok = 1'b1; break; end
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL a_idle_timeout: returned=%0b required=1", ok); end
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic wait_idle_b();
    bit seen = 1'b0;
    bit ok = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      if (b_if.BUSY === 1'b1) seen = 1'b1;
      else if (seen) begin ok = 1'b1; break; end
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL b_idle_timeout: returned=%0b required=1", ok); end
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      a_if.TRIGGER = ~a_if.TRIGGER;
      b_if.TRIGGER = ~b_if.TRIGGER;
      tests++;
      if ({a_if.XFR_CLK, a_if.SERIAL_OUT, a_if.BUSY, a_if.DONE} !== 5'b11100) begin
        fails++;
        $display("FAIL reset_a cyc%0d: xfr/sout/busy/done=%b required 11100", i,
                 {a_if.XFR_CLK, a_if.SERIAL_OUT, a_if.BUSY, a_if.DONE});
      end
      tests++;
      if ({b_if.XFR_CLK, b_if.SERIAL_OUT, b_if.BUSY, b_if.DONE} !== 5'b11100) begin
        fails++;
        $display("FAIL reset_b cyc%0d: xfr/sout/busy/done=%b required 11100", i,
                 {b_if.XFR_CLK, b_if.SERIAL_OUT, b_if.BUSY, b_if.DONE});
      end
    end
    tests++;
    if ({a_if.DBG1, a_if.DBG2} !== 2'b01) begin
      fails++; $display("FAIL reset_dbg: dbg1/dbg2=%b required 01", {a_if.DBG1, a_if.DBG2});
    end
    a_if.TRIGGER = 1'b0;
    b_if.TRIGGER = 1'b0;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    tests++;
    if ({a_if.BUSY, b_if.BUSY, a_if.XFR_CLK} !== 3'b001) begin
      fails++; $display("FAIL post_reset_idle: busy_a/busy_b/xfr=%b required 001",
                        {a_if.BUSY, b_if.BUSY, a_if.XFR_CLK});
    end
  endtask

  task automatic test_mode0();
    start_a(2'd0);
    wait_idle_a();
    for (int c = 0; c < 2; c++)
      for (int w = 0; w < A_NW; w++) begin
        tests++;
        if (a_word[c][w][11:0] !== a_exp[c][w] || a_par[c][w] !== a_exp_par[c][w]) begin
          fails++;
          $display("FAIL mode0 lane%0d word%0d: got %h/p%b required %h/p%b", c, w,
                   a_word[c][w][11:0], a_par[c][w], a_exp[c][w], a_exp_par[c][w]);
        end
      end
    tests++;
    if (a_gate !== 68) begin fails++; $display("FAIL mode0_gate: got %0d required 68", a_gate); end
    tests++;
    if (a_done !== 1 || a_bad_done !== 0) begin
      fails++; $display("FAIL mode0_done: got %0d (busy-overlap %0d) required 1 (0)", a_done, a_bad_done);
    end
    tests++;
    if (a_first_busy !== a_trig + 3) begin
      fails++; $display("FAIL mode0_busy_lat: got %0d required %0d", a_first_busy, a_trig + 3);
    end
    tests++;
    if (a_first_gate !== a_trig + 3 + A_DLY) begin
      fails++; $display("FAIL mode0_gate_lat: got %0d required %0d", a_first_gate, a_trig + 3 + A_DLY);
    end
  endtask

  task automatic test_perr();
    start_a(2'd3);
    wait_idle_a();
    for (int c = 0; c < 2; c++)
      for (int w = 0; w < A_NW; w++) begin
        tests++;
        if (a_word[c][w][11:0] !== a_exp[c][w] ||
            (^{a_word[c][w][11:0], a_par[c][w]}) !== (w != A_ERR)) begin
          fails++;
          $display("FAIL perr lane%0d word%0d: got %h odd=%b required %h odd=%b", c, w,
                   a_word[c][w][11:0], ^{a_word[c][w][11:0], a_par[c][w]}, a_exp[c][w], (w != A_ERR));
        end
      end
  endtask

  task automatic test_trig_mid_data();
    bit busy_seen = 1'b0;
    start_a(2'd0);
    for (int i = 0; i < 200 && a_gate < 20; i++) begin @(posedge clk); #1; end
    a_if.TRIGGER = 1'b1;
    repeat (3) @(posedge clk);
    #1 a_if.TRIGGER = 1'b0;
    wait_idle_a();
    tests++;
    if (a_gate !== 68) begin fails++; $display("FAIL trig_mid_gate: got %0d required 68", a_gate); end
    tests++;
    if (a_done !== 1) begin fails++; $display("FAIL trig_mid_done: got %0d required 1", a_done); end
    for (int w = 0; w < A_NW; w++) begin
      tests++;
      if (a_word[1][w][11:0] !== a_exp[1][w]) begin
        fails++; $display("FAIL trig_mid lane1 word%0d: got %h required %h", w, a_word[1][w][11:0], a_exp[1][w]);
      end
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (a_if.BUSY !== 1'b0) busy_seen = 1'b1;
    end
    tests++;
    if (busy_seen) begin fails++; $display("FAIL trig_mid_requeue: busy=%b required 0", busy_seen); end
  endtask

  task automatic test_enable_drop();
    start_a(2'd0);
    for (int i = 0; i < 200 && a_gate < A_PRE + 13 + 3; i++) begin @(posedge clk); #1; end
    a_if.ENABLE = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({a_if.XFR_CLK, a_if.BUSY} !== 2'b01) begin
      fails++; $display("FAIL en_drop_before: xfr/busy=%b required 01", {a_if.XFR_CLK, a_if.BUSY});
    end
    @(posedge clk); #1;
    tests++;
    if ({a_if.XFR_CLK, a_if.SERIAL_OUT, a_if.BUSY, a_if.DONE} !== 5'b11100) begin
      fails++; $display("FAIL en_drop_after: xfr/sout/busy/done=%b required 11100",
                        {a_if.XFR_CLK, a_if.SERIAL_OUT, a_if.BUSY, a_if.DONE});
    end
    repeat (10) @(posedge clk);
    #2;
    tests++;
    if (a_done !== 0) begin fails++; $display("FAIL en_drop_done: got %0d required 0", a_done); end
    // A trigger while disabled must be lost.
    start_a(2'd0);
    repeat (20) @(posedge clk);
    #1;
    tests++;
    if (a_if.BUSY !== 1'b0) begin fails++; $display("FAIL en_low_trigger: busy=%b required 0", a_if.BUSY); end
    a_if.ENABLE = 1'b1;
    repeat (4) @(posedge clk);
    start_a(2'd0);
    wait_idle_a();
    for (int c = 0; c < 2; c++)
      for (int w = 0; w < A_NW; w++) begin
        tests++;
        if (a_word[c][w][11:0] !== a_exp[c][w] || a_par[c][w] !== a_exp_par[c][w]) begin
          fails++;
          $display("FAIL re_enable lane%0d word%0d: got %h/p%b required %h/p%b", c, w,
                   a_word[c][w][11:0], a_par[c][w], a_exp[c][w], a_exp_par[c][w]);
        end
      end
    tests++;
    if (a_gate !== 68 || a_done !== 1) begin
      fails++; $display("FAIL re_enable_counts: gate=%0d done=%0d required 68 1", a_gate, a_done);
    end
  endtask

  task automatic test_walk();
    start_b(2'd1);
    wait_idle_b();
    for (int c = 0; c < 2; c++)
      for (int w = 0; w < B_NW; w++) begin
        tests++;
        if (b_word[c][w][3:0] !== b_walk[w] || b_par[c][w] !== 1'b0) begin
          fails++;
          $display("FAIL walk lane%0d word%0d: got %h/p%b required %h/p0", c, w,
                   b_word[c][w][3:0], b_par[c][w], b_walk[w]);
        end
      end
    tests++;
    if (b_gate !== 33) begin fails++; $display("FAIL walk_gate: got %0d required 33", b_gate); end
    tests++;
    if (b_first_gate !== b_trig + 3 + B_DLY) begin
      fails++; $display("FAIL walk_data_lat: got %0d required %0d", b_first_gate, b_trig + 3 + B_DLY);
    end
    tests++;
    if (b_done !== 1 || b_bad_done !== 0) begin
      fails++; $display("FAIL walk_done: got %0d/%0d required 1/0", b_done, b_bad_done);
    end
  endtask

  task automatic test_const_mode_change();
    start_b(2'd2);
    b_if.MODE = 2'd1;
    wait_idle_b();
    for (int c = 0; c < 2; c++)
      for (int w = 0; w < B_NW; w++) begin
        tests++;
        if (b_word[c][w][3:0] !== 4'hA || b_par[c][w] !== 1'b1) begin
          fails++;
          $display("FAIL const lane%0d word%0d: got %h/p%b required a/p1", c, w,
                   b_word[c][w][3:0], b_par[c][w]);
        end
      end
    tests++;
    if (b_done !== 1) begin fails++; $display("FAIL const_done: got %0d required 1", b_done); end
  endtask

  initial begin
    a_if.ENABLE = 1'b1; a_if.TRIGGER = 1'b0; a_if.MODE = 2'd0;
    b_if.ENABLE = 1'b1; b_if.TRIGGER = 1'b0; b_if.MODE = 2'd0;
    a_first_gate = -1; a_first_busy = -1; b_first_gate = -1; b_first_busy = -1;
    test_reset();
    test_mode0();
    test_perr();
    test_trig_mid_data();
    test_enable_drop();
    test_walk();
    test_const_mode_change();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
